// File: rtl/game_input_if.sv
// Pointer/button bundle between the board front end and its driver.
// master drives raw pointer and button levels, slave returns cursor, area flag and command pulses.
interface game_input_if;
  logic [9:0] mouse_x;
  logic [9:0] mouse_y;
  logic       btn_left;
  logic       btn_right;
  logic       btn_retract;
  logic       btn_retry;
  logic [5:0] cursor;
  logic       game_area;
  logic       left;
  logic       right;
  logic       retract;
  logic       retry;

  modport master (
    output mouse_x, mouse_y, btn_left, btn_right, btn_retract, btn_retry,
    input  cursor, game_area, left, right, retract, retry
  );

  modport slave (
    input  mouse_x, mouse_y, btn_left, btn_right, btn_retract, btn_retry,
    output cursor, game_area, left, right, retract, retry
  );
endinterface

// File: rtl/game_input.sv
// Board front end: pointer -> 8x8 cursor/game_area, buttons -> sync, debounce, press arbitration.
// Optional retract auto-repeat is built when GAME_INPUT_REPEAT_EN is defined.
module game_input #(
  parameter int unsigned ORIGIN_X        = 192,
  parameter int unsigned ORIGIN_Y        = 112,
  parameter int unsigned CELL_SHIFT      = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_CYCLES   = 20
) (
  input  logic         clk,
  input  logic         rst,
  game_input_if.slave  bus
);

  localparam int unsigned NUM_BTN  = 4;
  localparam int unsigned POS_W    = 11;
  localparam int unsigned BOARD_PX = 8 << CELL_SHIFT;
  localparam int unsigned DEB_W    = $clog2(DEBOUNCE_CYCLES);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_param
    $error("game_input: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 2");
  end

  // ---------------------------------------------------------------- pointer
  logic [POS_W-1:0] dx_c;
  logic [POS_W-1:0] dy_c;
  logic             inside_c;
  logic [5:0]       cursor_q;
  logic             game_area_q;

  assign dx_c = {1'b0, bus.mouse_x} - POS_W'(ORIGIN_X);
  assign dy_c = {1'b0, bus.mouse_y} - POS_W'(ORIGIN_Y);

  // Sign bit clear means the pointer is right of / below the origin.
  assign inside_c = !dx_c[POS_W-1] && (dx_c < POS_W'(BOARD_PX)) &&
                    !dy_c[POS_W-1] && (dy_c < POS_W'(BOARD_PX));

  always_ff @(posedge clk) begin
    if (rst) begin
      cursor_q    <= '0;
      game_area_q <= 1'b0;
    end else begin
      game_area_q <= inside_c;
      if (inside_c) begin
        cursor_q <= {dy_c[CELL_SHIFT +: 3], dx_c[CELL_SHIFT +: 3]};
      end
    end
  end

  assign bus.cursor    = cursor_q;
  assign bus.game_area = game_area_q;

  // ---------------------------------------------------------------- buttons
  // Bit order everywhere: {retry, retract, right, left}; higher index = higher priority.
  logic [NUM_BTN-1:0] raw_c;
  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;
  logic [NUM_BTN-1:0] deb;
  logic [DEB_W-1:0]   deb_cnt [NUM_BTN];
  logic [NUM_BTN-1:0] press_c;
  logic [NUM_BTN-1:0] fall_c;
  logic [NUM_BTN-1:0] rpt_set_c;
  logic [NUM_BTN-1:0] pend;
  logic [NUM_BTN-1:0] grant_c;
  logic [NUM_BTN-1:0] pulse_q;

  assign raw_c = {bus.btn_retry, bus.btn_retract, bus.btn_right, bus.btn_left};

  // A flip happens on the DEBOUNCE_CYCLES-th consecutive mismatching sample.
  always_comb begin
    press_c = '0;
    fall_c  = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if ((sync2[i] != deb[i]) && (deb_cnt[i] == DEB_W'(DEBOUNCE_CYCLES - 1))) begin
        press_c[i] = sync2[i];
        fall_c[i]  = !sync2[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      sync1 <= raw_c;
      sync2 <= sync1;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (press_c[i] || fall_c[i]) begin
          deb_cnt[i] <= '0;
          deb[i]     <= sync2[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

`ifdef GAME_INPUT_REPEAT_EN
  // Retract auto-repeat: re-arm the pending flag every REPEAT_CYCLES while held.
  localparam int unsigned RPT_W       = $clog2(REPEAT_CYCLES);
  localparam int unsigned BTN_RETRACT = 2;

  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_hit_c;

  assign rpt_hit_c = deb[BTN_RETRACT] && !fall_c[BTN_RETRACT] &&
                     (rpt_cnt == RPT_W'(REPEAT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_cnt <= '0;
    end else if (!deb[BTN_RETRACT] || fall_c[BTN_RETRACT] || rpt_hit_c) begin
      rpt_cnt <= '0;
    end else begin
      rpt_cnt <= rpt_cnt + RPT_W'(1);
    end
  end

  always_comb begin
    rpt_set_c              = '0;
    rpt_set_c[BTN_RETRACT] = rpt_hit_c;
  end
`else
  assign rpt_set_c = '0;
`endif

  // Fixed-priority pick of the highest pending command.
  always_comb begin
    grant_c = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (pend[i]) begin
        grant_c    = '0;
        grant_c[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend    <= '0;
      pulse_q <= '0;
    end else begin
      pend    <= (pend & ~grant_c) | press_c | rpt_set_c;
      pulse_q <= grant_c;
    end
  end

  assign bus.left    = pulse_q[0];
  assign bus.right   = pulse_q[1];
  assign bus.retract = pulse_q[2];
  assign bus.retry   = pulse_q[3];

endmodule

// File: tb/tb_game_input.sv
// Bench for game_input: directed pointer/button scenarios plus random button traffic
// compared against an event-level reference model.
module tb_game_input;

  localparam int DEB = 4;
  localparam int REP = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  game_input_if bus ();

  game_input #(
    .ORIGIN_X(192), .ORIGIN_Y(112), .CELL_SHIFT(5),
    .DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [3:0] pulses;
  assign pulses = {bus.retry, bus.retract, bus.right, bus.left};

  // ---------------- reference model state
  logic [3:0] m_q [$];
  int         m_run [4];
  logic [3:0] m_deb;
  logic [3:0] m_pend;
  int         m_rcnt;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_buttons(input logic [3:0] b);
    bus.btn_left    = b[0];
    bus.btn_right   = b[1];
    bus.btn_retract = b[2];
    bus.btn_retry   = b[3];
  endtask

  task automatic model_reset;
    m_q.delete();
    for (int b = 0; b < 4; b++) m_run[b] = 0;
    m_deb  = '0;
    m_pend = '0;
    m_rcnt = 0;
  endtask

  // One clock edge: raw r is what the DUT sees at this edge; exp is the pulse vector after it.
  task automatic model_edge(input logic [3:0] r, output logic [3:0] exp);
    logic [3:0] samp;
    logic [3:0] press;
    logic [3:0] deb_before;
    logic       fell;
    m_q.push_back(r);
    while (m_q.size() > 3) void'(m_q.pop_front());
    samp       = (m_q.size() == 3) ? m_q[0] : 4'b0;
    press      = '0;
    fell       = 1'b0;
    deb_before = m_deb;
    for (int b = 0; b < 4; b++) begin
      if (samp[b] != m_deb[b]) begin
        m_run[b]++;
        if (m_run[b] == DEB) begin
          m_run[b] = 0;
          m_deb[b] = samp[b];
          if (samp[b]) press[b] = 1'b1;
          else if (b == 2) fell = 1'b1;
        end
      end else begin
        m_run[b] = 0;
      end
    end
    exp = '0;
    for (int b = 3; b >= 0; b--) begin
      if (m_pend[b] && exp == 4'b0) exp[b] = 1'b1;
    end
    m_pend = (m_pend & ~exp) | press;
`ifdef GAME_INPUT_REPEAT_EN
    if (press[2] || !deb_before[2] || fell) begin
      m_rcnt = 0;
    end else begin
      m_rcnt++;
      if (m_rcnt == REP) begin
        m_rcnt    = 0;
        m_pend[2] = 1'b1;
      end
    end
`else
    if (fell && deb_before[2]) m_rcnt = 0;
`endif
  endtask

  task automatic do_reset;
    rst = 1'b1;
    set_buttons(4'b0000);
    tick;
    tick;
    model_reset();
  endtask

  // Runs edges 0..n-1 with buttons b held, expecting pulse vector e1 after edge k1 and e2 after k2.
  task automatic run_expect(input string name, input logic [3:0] b, input int n,
                            input int k1, input logic [3:0] e1,
                            input int k2, input logic [3:0] e2);
    logic [3:0] exp;
    rst = 1'b0;
    set_buttons(b);
    for (int k = 0; k < n; k++) begin
      tick;
      exp = (k == k1) ? e1 : (k == k2) ? e2 : 4'b0;
      n_checks++;
      if (pulses !== exp) $display("FAIL %s edge %0d: pulses=%b expected=%b", name, k, pulses, exp);
      else n_pass++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    set_buttons(4'b1111);
    bus.mouse_x = 10'd300;
    bus.mouse_y = 10'd200;
    tick; tick; tick;
    n_checks++;
    if ({bus.cursor, bus.game_area, pulses} !== 11'b0)
      $display("FAIL reset: cursor=%0d area=%b pulses=%b expected all 0", bus.cursor, bus.game_area, pulses);
    else n_pass++;
  endtask

  task automatic test_position;
    int mx [5] = '{293, 191, 447, 448, 192};
    int my [5] = '{177, 177, 367, 200, 112};
    int ec [5] = '{19, 19, 63, 63, 0};
    int ea [5] = '{1, 0, 1, 0, 1};
    int cur;
    int dx, dy;
    logic in_b;
    do_reset();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.mouse_x = 10'(mx[i]);
      bus.mouse_y = 10'(my[i]);
      tick;
      n_checks++;
      if (bus.cursor !== 6'(ec[i]) || bus.game_area !== 1'(ea[i]))
        $display("FAIL position %0d: cursor=%0d area=%b expected cursor=%0d area=%0d",
                 i, bus.cursor, bus.game_area, ec[i], ea[i]);
      else n_pass++;
    end
    cur = 0;
    for (int i = 0; i < 60; i++) begin
      bus.mouse_x = 10'($urandom_range(150, 500));
      bus.mouse_y = 10'($urandom_range(70, 420));
      dx = int'(bus.mouse_x) - 192;
      dy = int'(bus.mouse_y) - 112;
      in_b = (dx >= 0 && dx < 256 && dy >= 0 && dy < 256);
      if (in_b) cur = (dy / 32) * 8 + dx / 32;
      tick;
      n_checks++;
      if (bus.cursor !== 6'(cur) || bus.game_area !== in_b)
        $display("FAIL position_rand (%0d,%0d): cursor=%0d area=%b expected cursor=%0d area=%b",
                 bus.mouse_x, bus.mouse_y, bus.cursor, bus.game_area, cur, in_b);
      else n_pass++;
    end
  endtask

  task automatic test_glitch;
    logic [3:0] exp;
    do_reset();
    rst = 1'b0;
    set_buttons(4'b0001);
    tick;
    tick;
    set_buttons(4'b0000);
    for (int k = 2; k < 16; k++) begin
      tick;
      exp = 4'b0;
      n_checks++;
      if (pulses !== exp) $display("FAIL glitch edge %0d: pulses=%b expected=%b", k, pulses, exp);
      else n_pass++;
    end
  endtask

  task automatic test_single_press;
    do_reset();
    run_expect("single_left", 4'b0001, 10, 6, 4'b0001, -1, 4'b0000);
    run_expect("left_release", 4'b0000, 12, -1, 4'b0000, -1, 4'b0000);
  endtask

  task automatic test_two_buttons;
    do_reset();
    run_expect("left_right", 4'b0011, 12, 6, 4'b0010, 7, 4'b0001);
  endtask

  task automatic test_all_four;
    logic [3:0] exp;
    do_reset();
    rst = 1'b0;
    set_buttons(4'b1111);
    for (int k = 0; k < 14; k++) begin
      tick;
      case (k)
        6:       exp = 4'b1000;
        7:       exp = 4'b0100;
        8:       exp = 4'b0010;
        9:       exp = 4'b0001;
        default: exp = 4'b0000;
      endcase
      n_checks++;
      if (pulses !== exp) $display("FAIL all_four edge %0d: pulses=%b expected=%b", k, pulses, exp);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    rst = 1'b0;
    set_buttons(4'b1000);
    tick; tick; tick;
    rst = 1'b1;
    set_buttons(4'b0000);
    tick;
    n_checks++;
    if ({bus.cursor, bus.game_area, pulses} !== 11'b0)
      $display("FAIL reset_mid in reset: cursor=%0d area=%b pulses=%b expected all 0",
               bus.cursor, bus.game_area, pulses);
    else n_pass++;
    run_expect("reset_mid_after", 4'b0000, 16, -1, 4'b0000, -1, 4'b0000);
  endtask

  task automatic test_hold_through_reset;
    rst = 1'b1;
    set_buttons(4'b0001);
    tick; tick;
    run_expect("held_through_reset", 4'b0001, 12, 6, 4'b0001, -1, 4'b0000);
  endtask

  task automatic test_repeat;
    logic [3:0] exp;
    logic       hit;
    do_reset();
    rst = 1'b0;
    set_buttons(4'b0100);
    for (int k = 0; k < 96; k++) begin
      if (k == 70) set_buttons(4'b0000);
      tick;
`ifdef GAME_INPUT_REPEAT_EN
      hit = (k == 6 || k == 26 || k == 46 || k == 66);
`else
      hit = (k == 6);
`endif
      exp = hit ? 4'b0100 : 4'b0000;
      n_checks++;
      if (pulses !== exp) $display("FAIL repeat edge %0d: pulses=%b expected=%b", k, pulses, exp);
      else n_pass++;
    end
  endtask

  task automatic test_random_buttons;
    logic [3:0] r;
    logic [3:0] exp;
    do_reset();
    rst = 1'b0;
    r = '0;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 7) == 0) r[$urandom_range(0, 3)] ^= 1'b1;
      set_buttons(r);
      tick;
      model_edge(r, exp);
      n_checks++;
      if (pulses !== exp) $display("FAIL random edge %0d: pulses=%b expected=%b", k, pulses, exp);
      else n_pass++;
      n_checks++;
      if ($countones(pulses) > 1) $display("FAIL exclusion edge %0d: pulses=%b expected at most one", k, pulses);
      else n_pass++;
    end
  endtask

  initial begin
    bus.mouse_x = '0;
    bus.mouse_y = '0;
    set_buttons(4'b0000);
    model_reset();
    test_reset();
    test_position();
    test_glitch();
    test_single_press();
    test_two_buttons();
    test_all_four();
    test_reset_mid();
    test_hold_through_reset();
    test_repeat();
    test_random_buttons();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
